// File: rtl/veritune_pkg.sv
// veritune_pkg: shared definitions for the Veritune record/playback engine.
// One-hot state encoding, the bit index of each state flag, and the
// playback step that reproduces the original pitch.
package veritune_pkg;

  typedef enum logic [3:0] {
    ST_I    = 4'b0001,
    ST_REC  = 4'b0010,
    ST_STOP = 4'b0100,
    ST_PLAY = 4'b1000
  } state_e;

  // Bit position of each state inside the one-hot vector.
  localparam int S_I_IDX    = 0;
  localparam int S_REC_IDX  = 1;
  localparam int S_STOP_IDX = 2;
  localparam int S_PLAY_IDX = 3;

  // Unity pitch for the default 8-bit step with 4 fractional bits (1.0).
  localparam int              UNITY_STEP_FRAC = 4;
  localparam logic [7:0]      UNITY_STEP      = 8'(1 << UNITY_STEP_FRAC);

endpackage

// File: rtl/veritune_sample_ram.sv
// veritune_sample_ram: single-port synchronous sample store.
// Write and read share one address; read data is registered, so a read
// issued on one edge is available after that edge (read-before-write).
module veritune_sample_ram #(
  parameter int SAMPLE_W   = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [SAMPLE_W-1:0]   wdata_i,
  output logic [SAMPLE_W-1:0]   rdata_o
);

  logic [SAMPLE_W-1:0] mem_q [1 << DEPTH_LOG2];
  logic [SAMPLE_W-1:0] rdata_q;

  // Synchronous write and registered read on the shared port.
  // NOTE: the array has no reset so it maps onto block RAM; its contents
  // survive reset and are only meaningful up to the recorded length.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/veritune_pitch_buffer.sv
// veritune_pitch_buffer: record/playback engine with fixed-point pitch step.
// Records Audio_In into RAM on Rec, holds on Stop, and replays on Play by
// stepping a fixed-point phase accumulator by Step on every Sample_En.
// Build option: define VERITUNE_LOOP_EN to wrap playback at the end of the
// buffer; without it, playback stops after the last in-range sample.
module veritune_pitch_buffer
  import veritune_pkg::*;
#(
  parameter int SAMPLE_W   = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int STEP_W     = 8,
  parameter int STEP_FRAC  = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Sample_En,
  input  logic                  Rec,
  input  logic                  Stop,
  input  logic                  Play,
  input  logic [STEP_W-1:0]     Step,
  input  logic [SAMPLE_W-1:0]   Audio_In,
  output logic [SAMPLE_W-1:0]   Audio_Out,
  output logic                  Audio_Valid,
  output logic [DEPTH_LOG2:0]   Length,
  output logic                  Full,
  output logic                  q_I,
  output logic                  q_Rec,
  output logic                  q_Stop,
  output logic                  q_Play
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam int PW    = DEPTH_LOG2 + 1 + STEP_FRAC;

  state_e                state_q, state_d;
  logic [LW-1:0]         length_q, length_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [SAMPLE_W-1:0]   audio_q;
  logic                  valid_q;

  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [SAMPLE_W-1:0]   ram_rdata;

  logic [PW-1:0]         phase_sum;
`ifdef VERITUNE_LOOP_EN
  logic [PW-1:0]         len_fix;
  logic [PW-1:0]         phase_wrap;
`endif

  // Step widened to the accumulator; the sum cannot overflow because
  // STEP_W <= DEPTH_LOG2 + STEP_FRAC.
  assign phase_sum = phase_q + {{(PW - STEP_W){1'b0}}, Step};
`ifdef VERITUNE_LOOP_EN
  assign len_fix    = {length_q, {STEP_FRAC{1'b0}}};
  assign phase_wrap = phase_sum - len_fix;
`endif

  // Next-state, pointer/accumulator update and RAM control.
  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    phase_d   = phase_q;
    rd_pend_d = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = phase_q[STEP_FRAC +: DEPTH_LOG2];

    case (state_q)
      ST_I: begin
        // Stop outranks Rec; Stop itself does nothing here.
        if (Rec && !Stop) begin
          state_d  = ST_REC;
          length_d = '0;
        end
      end

      ST_REC: begin
        // Write pointer is the current length; Rec and Play are ignored.
        ram_addr = length_q[DEPTH_LOG2-1:0];
        if (Stop) begin
          state_d = ST_STOP;
        end else if (Sample_En) begin
          ram_we   = 1'b1;
          length_d = length_q + LW'(1);
          if (length_q == LW'(DEPTH - 1)) begin
            state_d = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        if (Stop) begin
          state_d = ST_STOP;
        end else if (Rec) begin
          state_d  = ST_REC;
          length_d = '0;
        end else if (Play && (length_q != '0)) begin
          state_d = ST_PLAY;
          phase_d = '0;
        end
      end

      ST_PLAY: begin
        // A command leaving PLAY cancels a coincident read.
        if (Stop) begin
          state_d = ST_STOP;
        end else if (Rec) begin
          state_d  = ST_REC;
          length_d = '0;
        end else if (Sample_En) begin
          rd_pend_d = 1'b1;
          phase_d   = phase_sum;
          if (phase_sum[PW-1:STEP_FRAC] >= length_q) begin
`ifdef VERITUNE_LOOP_EN
            phase_d = (phase_wrap >= len_fix) ? '0 : phase_wrap;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end

      default: state_d = ST_I;
    endcase
  end

  // State, length, phase and read-pending registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_I;
      length_q  <= '0;
      phase_q   <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      length_q  <= length_d;
      phase_q   <= phase_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Output register: captures RAM data one edge after the read was issued.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      audio_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        audio_q <= ram_rdata;
      end
    end
  end

  veritune_sample_ram #(
    .SAMPLE_W   (SAMPLE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (Clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (Audio_In),
    .rdata_o (ram_rdata)
  );

  assign Audio_Out   = audio_q;
  assign Audio_Valid = valid_q;
  assign Length      = length_q;
  assign Full        = length_q[DEPTH_LOG2];
  assign q_I         = state_q[S_I_IDX];
  assign q_Rec       = state_q[S_REC_IDX];
  assign q_Stop      = state_q[S_STOP_IDX];
  assign q_Play      = state_q[S_PLAY_IDX];

endmodule
